// File: rtl/mux_arbitrado_nx1.sv
// N-to-1 valid/ready selector with a registered output; fixed select or round-robin.
// Optional accepted-transfer counter on Cuenta_out when MUX_CONTADOR_EN is defined.
module mux_arbitrado_nx1 #(
  parameter  int WIDTH   = 5,
  parameter  int CANALES = 4,
  localparam int SEL_W   = $clog2(CANALES)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       Modo,
  input  logic [SEL_W-1:0]           Control,
  input  logic [CANALES*WIDTH-1:0]   Entrada,
  input  logic [CANALES-1:0]         Valido_in,
  output logic [CANALES-1:0]         Listo_in,
  output logic [WIDTH-1:0]           Salida,
  output logic                       Valido_out,
  output logic [SEL_W-1:0]           Canal_out,
  input  logic                       Listo_out
`ifdef MUX_CONTADOR_EN
  ,
  output logic [15:0]                Cuenta_out
`endif
);

  logic [WIDTH-1:0] salida_q, salida_d;
  logic             valido_q, valido_d;
  logic [SEL_W-1:0] canal_q, canal_d;
  logic [SEL_W-1:0] puntero_q, puntero_d;

  logic             carga;
  logic             grant_vld;
  logic [SEL_W-1:0] grant_idx;
  logic             transfer;
  int               idx;

  assign carga = !valido_q || Listo_out;

  // Fixed mode compares Control against every legal index, so an
  // out-of-range Control simply matches nothing.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    if (!Modo) begin
      for (int i = 0; i < CANALES; i++) begin
        if (Control == SEL_W'(i) && Valido_in[i]) begin
          grant_vld = 1'b1;
          grant_idx = SEL_W'(i);
        end
      end
    end else begin
      for (int k = 0; k < CANALES; k++) begin
        idx = (int'(puntero_q) + k) % CANALES;
        if (!grant_vld && Valido_in[idx]) begin
          grant_vld = 1'b1;
          grant_idx = SEL_W'(idx);
        end
      end
    end
  end

  always_comb begin
    Listo_in = '0;
    for (int i = 0; i < CANALES; i++) begin
      Listo_in[i] = !reset && carga && grant_vld && (grant_idx == SEL_W'(i));
    end
  end

  assign transfer = |(Valido_in & Listo_in);

  always_comb begin
    salida_d  = salida_q;
    valido_d  = valido_q;
    canal_d   = canal_q;
    puntero_d = puntero_q;
    if (transfer) begin
      for (int i = 0; i < CANALES; i++) begin
        if (grant_idx == SEL_W'(i)) salida_d = Entrada[i*WIDTH +: WIDTH];
      end
      valido_d  = 1'b1;
      canal_d   = grant_idx;
      puntero_d = (grant_idx == SEL_W'(CANALES-1)) ? '0 : grant_idx + SEL_W'(1);
    end else if (Listo_out) begin
      valido_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      salida_q  <= '0;
      valido_q  <= 1'b0;
      canal_q   <= '0;
      puntero_q <= '0;
    end else begin
      salida_q  <= salida_d;
      valido_q  <= valido_d;
      canal_q   <= canal_d;
      puntero_q <= puntero_d;
    end
  end

  assign Salida     = salida_q;
  assign Valido_out = valido_q;
  assign Canal_out  = canal_q;

`ifdef MUX_CONTADOR_EN
  logic [15:0] cuenta_q, cuenta_d;

  // Saturating: stays at 16'hFFFF rather than wrapping.
  always_comb begin
    cuenta_d = cuenta_q;
    if (transfer && cuenta_q != 16'hFFFF) cuenta_d = cuenta_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cuenta_q <= '0;
    else       cuenta_q <= cuenta_d;
  end

  assign Cuenta_out = cuenta_q;
`endif

endmodule

// File: doc/mux_arbitrado_nx1.md
# mux_arbitrado_nx1

Parametrised N-to-1 selector with a registered output and valid/ready flow control. It generalises the 2:1 operand and immediate-field multiplexers of the datapath to CANALES inputs of WIDTH bits. It adds two selection modes: explicit select through `Control`, or round-robin among requesting channels. It sits between multi-source producers (immediate assembly, writeback sources, forwarding candidates) and a single consumer stage, and supplies one pipeline register with backpressure.

## Interface
- `WIDTH`, default 5, data width per channel (≥1).
- `CANALES`, default 4, number of input channels (≥2). Derived, not overridable: `SEL_W = $clog2(CANALES)`.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `Modo`  in  1  0 = fixed select via `Control`; 1 = round-robin.
- `Control`  in  SEL_W  channel index used when `Modo`=0.
- `Entrada`  in  CANALES*WIDTH  flattened inputs; channel i at `[i*WIDTH +: WIDTH]`.
- `Valido_in`  in  CANALES  per-channel valid.
- `Listo_in`  out  CANALES  per-channel ready; one-hot or zero.
- `Salida`  out  WIDTH  registered selected data.
- `Valido_out`  out  1  `Salida` holds valid data.
- `Canal_out`  out  SEL_W  index of the channel that produced `Salida`.
- `Listo_out`  in  1  downstream ready.
- `Cuenta_out`  out  16  accepted-transfer count. Present only with `MUX_CONTADOR_EN`.

## Operation
- `carga = !Valido_out || Listo_out`. The output register can accept new data this cycle.
- Grant, `Modo`=0:
  - grant = `Control` if `Control` < CANALES and `Valido_in[Control]`.
  - Otherwise no grant.
  - Other channels are never granted, even if valid.
- Grant, `Modo`=1:
  - Search channels starting at `puntero` and wrapping modulo CANALES.
  - The first channel with `Valido_in` set is granted.
  - No valid channel means no grant.
- `Listo_in[i] = carga && grant valid && (i == grant)`. All zero while `reset`=1.
- Transfer on channel i occurs when `Valido_in[i] && Listo_in[i]`. On a transfer:
  - `Salida` ← channel i data.
  - `Canal_out` ← i.
  - `Valido_out` ← 1.
  - `puntero` ← (i+1) mod CANALES. This update happens in both modes.
- No transfer and `Listo_out`=1: `Valido_out` ← 0. `Salida` and `Canal_out` hold their last value.
- No transfer and `Listo_out`=0: all output registers hold.
- A mode switch takes effect on the next grant evaluation. Registered data is unaffected.
- Channel data is sampled only on the transfer edge. Upstream must hold data while `Valido_in`=1 and `Listo_in`=0.

## Timing
- Reset (synchronous, active-high, priority over everything) sets:
  - `Salida`=0, `Valido_out`=0, `Canal_out`=0, `puntero`=0, `Cuenta_out`=0.
- Latency is 1 cycle from the transfer edge to `Salida`/`Valido_out`.
- Throughput is 1 transfer per cycle while `Listo_out`=1.
- Backpressure: with `Valido_out`=1 and `Listo_out`=0, `carga`=0, so all `Listo_in`=0. Output holds stable until the consumer accepts.
- Simultaneous accept and new transfer in one cycle: the consumer takes the old word and the register loads the new word. There is no bubble.
- Reset asserted mid-transfer: the pending transfer is dropped, no `Listo_in` is asserted, and the counter does not increment.
- `Listo_in` is combinational from `Valido_in`, `Modo`, `Control`, `Listo_out` and state. There is no combinational path from `Entrada` to any output.
- Round-robin wrap: after a grant to channel CANALES-1, `puntero` returns to 0.

## Configuration
- `MUX_CONTADOR_EN` defined:
  - Adds port `Cuenta_out`, a 16-bit counter.
  - Increments by 1 on every transfer.
  - Saturates at 16'hFFFF and does not wrap.
  - Cleared by `reset`.
- Undefined: the port and counter logic are absent. All other behaviour is identical.

## Test plan
WIDTH=5, CANALES=4 unless noted.
- Reset: hold `reset`=1 for 2 cycles with all `Valido_in`=4'b1111 → `Listo_in`=0, `Salida`=0, `Valido_out`=0, `Canal_out`=0. After release, the first transfer is from channel 0 in `Modo`=1.
- Fixed select: `Modo`=0, `Control`=2, `Valido_in`=4'b0110, ch2=5'h15, `Listo_out`=1 → `Listo_in`=4'b0100. Next cycle `Salida`=5'h15, `Canal_out`=2, `Valido_out`=1.
- Invalid selected channel: `Modo`=0, `Control`=3, `Valido_in`=4'b0011 → `Listo_in`=0. `Valido_out` drops to 0 on the next edge.
- Round-robin fairness: `Modo`=1, all valid, `Listo_out`=1 for 6 cycles → `Canal_out` sequence is 0,1,2,3,0,1. Valid every cycle.
- Backpressure: `Valido_out`=1 with `Salida`=5'h0A, `Listo_out`=0 for 3 cycles, all inputs valid → `Listo_in`=0 and `Salida` stays 5'h0A. On the cycle `Listo_out` returns to 1, the new word loads with no bubble.
- With `MUX_CONTADOR_EN`: 5 transfers give `Cuenta_out`=5. Preload the counter by forcing it to 16'hFFFE, then perform 3 transfers → `Cuenta_out`=16'hFFFF. `reset` → 0.
